// File: rtl/crc8_rx_check.sv
// -----------------------------------------------------------------------------
// crc8_rx_check
//
// Receive-side CRC-8/CCITT checker (poly x^8+x^2+x+1 = 0x07, MSB-first,
// no reflection, no final XOR). It sits after the byte deframer. Every accepted
// byte of a frame, including the trailing CRC byte, is folded into a running
// CRC. A zero residue after the eop byte means the frame is intact.
//
// Parameters
//   INIT     CRC preset loaded at every start of frame
//   MIN_LEN  shortest legal frame in bytes, CRC byte included
//   LEN_W    width of the byte counter and of len_o
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   data_i       frame byte
//   valid_i      byte strobe; nothing is accepted while low
//   sop_i        first byte of frame (qualified by valid_i)
//   eop_i        last byte of frame = CRC byte (qualified by valid_i)
//   done_o       1-cycle pulse, verdict outputs updated
//   crc_ok_o     residue 0 and length >= MIN_LEN; held until next done_o
//   crc_err_o    bad residue or runt; held until next done_o
//   runt_o       length < MIN_LEN; held until next done_o
//   abort_o      1-cycle pulse, a frame was cut off by a new sop_i
//   len_o        byte count of last completed frame (saturating); held
//   crc_o        running CRC register (debug)
//   busy_o       a frame is in progress
//   err_cnt_o    only with CRC8_RX_ERRCNT_EN: saturating count of failed
//                verdicts plus aborts, cleared only by rst
//
// Build option: define CRC8_RX_ERRCNT_EN to add err_cnt_o and its counter.
// -----------------------------------------------------------------------------
module crc8_rx_check #(
    parameter logic [7:0] INIT    = 8'h00,
    parameter int         MIN_LEN = 2,
    parameter int         LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    input  logic             sop_i,
    input  logic             eop_i,
    output logic             done_o,
    output logic             crc_ok_o,
    output logic             crc_err_o,
    output logic             runt_o,
    output logic             abort_o,
    output logic [LEN_W-1:0] len_o,
    output logic [7:0]       crc_o,
    output logic             busy_o
`ifdef CRC8_RX_ERRCNT_EN
    ,
    output logic [15:0]      err_cnt_o
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    // Verdict produced in the cycle the eop byte is accepted.
    typedef struct packed {
        logic             fin;
        logic             ok;
        logic             runt;
        logic [LEN_W-1:0] len;
    } verdict_t;

    state_t           state;
    logic [7:0]       crc_q;
    logic [LEN_W-1:0] cnt;

    // One byte of CRC-8/CCITT folded in parallel. x = seed ^ data, then the
    // eight shift/xor steps of the 0x07 polynomial collapse to these terms.
    function automatic logic [7:0] crc8_next(input logic [7:0] seed,
                                             input logic [7:0] d);
        logic [7:0] x;
        logic [7:0] n;
        x    = seed ^ d;
        n[0] = x[0] ^ x[6] ^ x[7];
        n[1] = x[0] ^ x[1] ^ x[6];
        n[2] = x[0] ^ x[1] ^ x[2] ^ x[6];
        n[3] = x[1] ^ x[2] ^ x[3] ^ x[7];
        n[4] = x[2] ^ x[3] ^ x[4];
        n[5] = x[3] ^ x[4] ^ x[5];
        n[6] = x[4] ^ x[5] ^ x[6];
        n[7] = x[5] ^ x[6] ^ x[7];
        return n;
    endfunction

    logic [7:0]       seed;
    logic [7:0]       crc_nxt;
    logic [LEN_W-1:0] cnt_inc;
    logic             crc_upd;
    logic             abort_hit;
    verdict_t         vd;

    // A sop byte always restarts from INIT, whatever state we are in.
    assign seed    = sop_i ? INIT : crc_q;
    assign crc_nxt = crc8_next(seed, data_i);

    // Saturating increment: a frame longer than the counter reports all-ones.
    assign cnt_inc = (cnt == {LEN_W{1'b1}}) ? cnt : cnt + LEN_W'(1);

    always_comb begin
        crc_upd   = 1'b0;
        abort_hit = 1'b0;
        vd        = '0;
        if (valid_i) begin
            if (sop_i) begin
                crc_upd   = 1'b1;
                // sop inside a frame abandons it; no verdict for the old one
                abort_hit = (state == BODY);
                if (eop_i) begin
                    vd.fin = 1'b1;
                    vd.len = LEN_W'(1);
                end
            end else if (state == BODY) begin
                crc_upd = 1'b1;
                if (eop_i) begin
                    vd.fin = 1'b1;
                    vd.len = cnt_inc;
                end
            end
            // valid byte without sop while IDLE: dropped silently
        end
        vd.runt = vd.fin && (vd.len < LEN_W'(MIN_LEN));
        // residue of the whole frame, CRC byte included, must be zero
        vd.ok   = vd.fin && (crc_nxt == 8'h00) && !vd.runt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_q     <= INIT;
            cnt       <= '0;
            done_o    <= 1'b0;
            crc_ok_o  <= 1'b0;
            crc_err_o <= 1'b0;
            runt_o    <= 1'b0;
            abort_o   <= 1'b0;
            len_o     <= '0;
        end else begin
            done_o  <= vd.fin;
            abort_o <= abort_hit;

            if (crc_upd)
                crc_q <= crc_nxt;

            if (valid_i) begin
                if (sop_i) begin
                    // single-byte frame finalises at once and stays IDLE
                    state <= eop_i ? IDLE : BODY;
                    cnt   <= eop_i ? '0 : LEN_W'(1);
                end else if (state == BODY) begin
                    if (eop_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            end

            // verdict flops only move on done, otherwise they hold
            if (vd.fin) begin
                len_o     <= vd.len;
                runt_o    <= vd.runt;
                crc_ok_o  <= vd.ok;
                crc_err_o <= !vd.ok;
            end
        end
    end

    assign crc_o  = crc_q;
    assign busy_o = (state == BODY);

`ifdef CRC8_RX_ERRCNT_EN
    // An abort and a failed single-byte restart can land in the same cycle,
    // so the step is 0, 1 or 2.
    logic [1:0]  err_step;
    logic [16:0] err_sum;

    assign err_step = 2'(vd.fin && !vd.ok) + 2'(abort_hit);
    assign err_sum  = {1'b0, err_cnt_o} + 17'(err_step);

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_o <= '0;
        else
            err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_crc8_rx_check.sv
// -----------------------------------------------------------------------------
// Bench for crc8_rx_check. Directed steps in one initial block; expected
// verdicts are queued when the eop byte is driven and popped by a monitor
// whenever done_o is seen. LEN_W is shrunk to 5 so counter saturation is
// reachable in a short frame.
// -----------------------------------------------------------------------------
module tb_crc8_rx_check;

    localparam int TB_LEN_W = 5;

    logic                clk;
    logic                rst;
    logic [7:0]          data;
    logic                valid;
    logic                sop;
    logic                eop;
    logic                done;
    logic                crc_ok;
    logic                crc_err;
    logic                runt;
    logic                abort_p;
    logic [TB_LEN_W-1:0] len;
    logic [7:0]          crc;
    logic                busy;
`ifdef CRC8_RX_ERRCNT_EN
    logic [15:0]         err_cnt;
`endif

    crc8_rx_check #(
        .INIT    (8'h00),
        .MIN_LEN (2),
        .LEN_W   (TB_LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data),
        .valid_i   (valid),
        .sop_i     (sop),
        .eop_i     (eop),
        .done_o    (done),
        .crc_ok_o  (crc_ok),
        .crc_err_o (crc_err),
        .runt_o    (runt),
        .abort_o   (abort_p),
        .len_o     (len),
        .crc_o     (crc),
        .busy_o    (busy)
`ifdef CRC8_RX_ERRCNT_EN
        ,
        .err_cnt_o (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                ok;
        logic                err;
        logic                runt;
        logic [TB_LEN_W-1:0] len;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   exp_errs = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial bit-at-a-time reference CRC, used to build a valid long frame.
    function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic push(input logic ok, input logic rn, input int l);
        exp_t e;
        e.ok   = ok;
        e.err  = !ok;
        e.runt = rn;
        e.len  = TB_LEN_W'(l);
        sb.push_back(e);
        if (!ok) exp_errs++;
    endtask

    // One cycle: drive at a negedge, return at the next negedge.
    task automatic send(input logic [7:0] d, input logic s, input logic e);
        valid = 1'b1;
        data  = d;
        sop   = s;
        eop   = e;
        @(negedge clk);
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int gap);
        foreach (q[i]) begin
            send(q[i], i == 0, i == q.size() - 1);
            if (gap > 0) idle(gap);
        end
    endtask

    // Verdict monitor: every done_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_done: observed=1 expected=0");
            end else begin
                mon_e = sb.pop_front();
                check("crc_ok",   32'(crc_ok),  32'(mon_e.ok));
                check("crc_err",  32'(crc_err), 32'(mon_e.err));
                check("runt",     32'(runt),    32'(mon_e.runt));
                check("len",      32'(len),     32'(mon_e.len));
            end
        end
    end

    initial begin
        logic [7:0] q[$];

        rst   = 1'b1;
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        data  = 8'h00;
        idle(3);

        // reset state
        check("rst_done",    32'(done),    32'd0);
        check("rst_ok",      32'(crc_ok),  32'd0);
        check("rst_err",     32'(crc_err), 32'd0);
        check("rst_runt",    32'(runt),    32'd0);
        check("rst_abort",   32'(abort_p), 32'd0);
        check("rst_len",     32'(len),     32'd0);
        check("rst_crc",     32'(crc),     32'h00);
        check("rst_busy",    32'(busy),    32'd0);
`ifdef CRC8_RX_ERRCNT_EN
        check("rst_errcnt",  32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        idle(1);

        // good 2-byte frame
        send(8'h01, 1'b1, 1'b0);
        check("good_crc_mid", 32'(crc),  32'h07);
        check("good_busy",    32'(busy), 32'd1);
        push(1'b1, 1'b0, 2);
        send(8'h07, 1'b0, 1'b1);
        idle(2);
        check("good_hold_ok", 32'(crc_ok), 32'd1);
        check("good_idle",    32'(busy),   32'd0);
        check("good_done_lo", 32'(done),   32'd0);

        // "123456789" + 0xF4, back to back then with valid gaps
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        push(1'b1, 1'b0, 10);
        send_frame(q, 0);
        push(1'b1, 1'b0, 10);
        send_frame(q, 1);
        idle(1);

        // corrupted CRC byte
        push(1'b0, 1'b0, 2);
        send(8'h01, 1'b1, 1'b0);
        send(8'h06, 1'b0, 1'b1);
        idle(1);
`ifdef CRC8_RX_ERRCNT_EN
        check("errcnt_corrupt", 32'(err_cnt), 32'd1);
`endif

        // runt: single zero byte, residue 0 but too short
        push(1'b0, 1'b1, 1);
        send(8'h00, 1'b1, 1'b1);
        idle(1);

        // stray byte in IDLE is dropped
        send(8'hAA, 1'b0, 1'b0);
        check("drop_crc",  32'(crc),     32'h00);
        check("drop_busy", 32'(busy),    32'd0);
        check("drop_err",  32'(crc_err), 32'd1);
        idle(1);

        // abort then restart
        send(8'h01, 1'b1, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        exp_errs++;
        check("abort_pulse", 32'(abort_p), 32'd1);
        push(1'b1, 1'b0, 2);
        send(8'h07, 1'b0, 1'b1);
        check("abort_drop",  32'(abort_p), 32'd0);
        idle(1);

        // consecutive single-byte frames, then back-to-back good frames
        push(1'b0, 1'b1, 1);
        send(8'h00, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1);
        send(8'h07, 1'b1, 1'b1);
        push(1'b1, 1'b0, 2);
        send(8'h01, 1'b1, 1'b0);
        send(8'h07, 1'b0, 1'b1);
        push(1'b1, 1'b0, 2);
        send(8'h01, 1'b1, 1'b0);
        send(8'h07, 1'b0, 1'b1);
        idle(1);

        // abort whose restart is itself a single-byte frame
        send(8'h01, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1);
        exp_errs++;
        send(8'h00, 1'b1, 1'b1);
        check("abort_single_pulse", 32'(abort_p), 32'd1);
        check("abort_single_busy",  32'(busy),    32'd0);
        idle(1);

        // length counter saturation: 40-byte valid frame reports all-ones
        q = {};
        for (int i = 0; i < 39; i++) q.push_back(8'(i * 13 + 5));
        q.push_back(ref_crc(q));
        push(1'b1, 1'b0, 31);
        send_frame(q, 0);
        idle(1);
`ifdef CRC8_RX_ERRCNT_EN
        check("errcnt_total", 32'(err_cnt), 32'(exp_errs));
`endif

        // reset mid-frame: frame discarded, trailing eop byte ignored
        send(8'h01, 1'b1, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mrst_ok",   32'(crc_ok),  32'd0);
        check("mrst_err",  32'(crc_err), 32'd0);
        check("mrst_len",  32'(len),     32'd0);
        check("mrst_busy", 32'(busy),    32'd0);
`ifdef CRC8_RX_ERRCNT_EN
        check("mrst_errcnt", 32'(err_cnt), 32'd0);
`endif
        send(8'h07, 1'b0, 1'b1);
        check("mrst_done",  32'(done),    32'd0);
        idle(2);
        check("mrst_crc",   32'(crc),     32'h00);
        check("mrst_abort", 32'(abort_p), 32'd0);
        check("mrst_ok2",   32'(crc_ok),  32'd0);

        // every queued verdict must have been delivered
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
